pipe_stage_skid: RTL and testbench

- Parametrised successor to the single-register valid/stall pipeline stage.
- Accepts words from stage n-1, applies a configurable per-word operation, and buffers results in a DEPTH-entry skid FIFO before presenting them to stage n+1.
- o_stall is fully registered: there is no combinational path from i_stall to o_stall, so long pipeline chains close timing.
- Adds flush, an internal-stall hook, an occupancy report and an overflow-free guarantee.

---
 rtl/pipe_stage_skid_if.sv | 29 ++
 rtl/pipe_stage_skid.sv | 75 +++++++
 tb/tb_pipe_stage_skid.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between stage n-1, the skid stage and stage n+1.
// The slave modport is the stage itself; master is its environment.
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic              i_flush;
    logic              i_internal_stall;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_stall;
    logic              o_current_ce;
    logic              i_stall;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic [CW-1:0]     o_count;

    modport slave (
        input  i_flush, i_internal_stall, i_data, i_valid, i_stall,
        output o_stall, o_current_ce, o_data, o_valid, o_count
    );

    modport master (
        output i_flush, i_internal_stall, i_data, i_valid, i_stall,
        input  o_stall, o_current_ce, o_data, o_valid, o_count
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with per-word operation and a DEPTH-entry skid FIFO;
// the upstream stall is registered so there is no i_stall -> o_stall path.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned MODE   = 1,
    parameter int unsigned INC    = 1
) (
    input logic              i_clk,
    input logic              i_rst,
    pipe_stage_skid_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] INC_W = DATA_W'(INC);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              stall_q;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] op_data;

    assign push = bus.i_valid && !stall_q && !bus.i_flush && !i_rst;
    assign pop  = bus.o_valid && !bus.i_stall;

    assign bus.o_valid      = (count != '0) && !bus.i_internal_stall;
    assign bus.o_data       = mem[rptr];
    assign bus.o_count      = count;
    assign bus.o_stall      = stall_q;
    assign bus.o_current_ce = push;

    always_comb begin
        sum = {1'b0, bus.i_data} + {1'b0, INC_W};
        op_data = bus.i_data;
        case (MODE)
            1:       op_data = sum[DATA_W-1:0];
            2:       op_data = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
            default: op_data = bus.i_data;
        endcase
    end

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            stall_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= op_data;
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
            end
            if (pop)
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
            count   <= count_next;
            // Full next cycle is known now, so stall is a plain register.
            stall_q <= (count_next == CW'(DEPTH));
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives three differently configured stages with shared stimulus and
// compares each against a queue-based reference of the stage's rules.
module tb_pipe_stage_skid;
    localparam int NK = 3;
    localparam int DEP  [NK] = '{2, 4, 3};
    localparam int MOD  [NK] = '{1, 2, 0};
    localparam int INCV [NK] = '{1, 3, 5};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        istall = 1'b0;
    logic        valid = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] data = '0;

    int checks = 0;
    int errors = 0;

    logic ov [NK];
    logic ost[NK];
    logic ce [NK];
    int   od [NK];
    int   oc [NK];

    int q[NK][$];
    bit st [NK];
    bit clr[NK];
    bit known = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(16), .DEPTH(2)) ifa ();
    pipe_stage_skid_if #(.DATA_W(16), .DEPTH(4)) ifb ();
    pipe_stage_skid_if #(.DATA_W(16), .DEPTH(3)) ifc ();

    pipe_stage_skid #(.DATA_W(16), .DEPTH(2), .MODE(1), .INC(1))
        dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa.slave));
    pipe_stage_skid #(.DATA_W(16), .DEPTH(4), .MODE(2), .INC(3))
        dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb.slave));
    pipe_stage_skid #(.DATA_W(16), .DEPTH(3), .MODE(0), .INC(5))
        dut_c (.i_clk(clk), .i_rst(rst), .bus(ifc.slave));

    assign ifa.i_flush = flush;  assign ifa.i_internal_stall = istall;
    assign ifa.i_data  = data;   assign ifa.i_valid = valid;  assign ifa.i_stall = stall;
    assign ifb.i_flush = flush;  assign ifb.i_internal_stall = istall;
    assign ifb.i_data  = data;   assign ifb.i_valid = valid;  assign ifb.i_stall = stall;
    assign ifc.i_flush = flush;  assign ifc.i_internal_stall = istall;
    assign ifc.i_data  = data;   assign ifc.i_valid = valid;  assign ifc.i_stall = stall;

    assign ov[0] = ifa.o_valid;  assign ost[0] = ifa.o_stall;  assign ce[0] = ifa.o_current_ce;
    assign od[0] = int'(ifa.o_data);  assign oc[0] = int'(ifa.o_count);
    assign ov[1] = ifb.o_valid;  assign ost[1] = ifb.o_stall;  assign ce[1] = ifb.o_current_ce;
    assign od[1] = int'(ifb.o_data);  assign oc[1] = int'(ifb.o_count);
    assign ov[2] = ifc.o_valid;  assign ost[2] = ifc.o_stall;  assign ce[2] = ifc.o_current_ce;
    assign od[2] = int'(ifc.o_data);  assign oc[2] = int'(ifc.o_count);

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int op(input int k, input int d);
        int s;
        s = d + INCV[k];
        case (MOD[k])
            1:       return s % 65536;
            2:       return (s > 65535) ? 65535 : s;
            default: return d;
        endcase
    endfunction

    task automatic cycle(input bit v, input int d, input bit s,
                         input bit is, input bit f, input bit r);
        bit expv;
        bit push;
        @(negedge clk);
        valid = v; data = 16'(d); stall = s; istall = is; flush = f; rst = r;
        #1;
        for (int k = 0; k < NK; k++) begin
            expv = (q[k].size() != 0) && !is;
            push = v && !st[k] && !f && !r;
            if (known) begin
                check($sformatf("valid%0d", k), int'(ov[k]), int'(expv));
                check($sformatf("stall%0d", k), int'(ost[k]), int'(st[k]));
                check($sformatf("ce%0d", k), int'(ce[k]), int'(push));
                check($sformatf("count%0d", k), oc[k], q[k].size());
                if (expv)
                    check($sformatf("data%0d", k), od[k], q[k][0]);
                else if (clr[k] && q[k].size() == 0)
                    check($sformatf("zero_data%0d", k), od[k], 0);
            end
            if (r || f) begin
                q[k].delete();
                st[k]  = 1'b0;
                clr[k] = 1'b1;
            end else begin
                if (expv && !s)
                    void'(q[k].pop_front());
                if (push) begin
                    q[k].push_back(op(k, d));
                    clr[k] = 1'b0;
                end
                st[k] = (q[k].size() == DEP[k]);
            end
        end
        if (r)
            known = 1'b1;
    endtask

    initial begin
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        // streaming
        for (int i = 0; i < 8; i++) cycle(1, i, 0, 0, 0, 0);
        // back-pressure then release
        cycle(1, 10, 0, 0, 0, 0);
        cycle(1, 11, 1, 0, 0, 0);
        cycle(1, 12, 1, 0, 0, 0);
        cycle(1, 12, 1, 0, 0, 0);
        cycle(1, 13, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 13 + i, 0, 0, 0, 0);
        // wrap / saturate / pass-through edge values
        cycle(1, 16'hFFFF, 0, 0, 0, 0);
        cycle(1, 16'hFFFE, 0, 0, 0, 0);
        cycle(1, 16'h1234, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // fill then flush with a word presented
        for (int i = 0; i < 5; i++) cycle(1, 100 + i, 1, 0, 0, 0);
        cycle(1, 200, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // internal stall while upstream streams
        for (int i = 0; i < 3; i++) cycle(1, 300 + i, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 310 + i, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0);
        // reset mid-stream
        cycle(1, 400, 1, 0, 0, 0);
        cycle(1, 401, 1, 0, 0, 0);
        cycle(1, 402, 1, 0, 0, 1);
        cycle(1, 403, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? 65535 - int'($urandom_range(0, 4))
                                            : int'($urandom_range(0, 65535));
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 79) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
